// File: rtl/rosc_freq_counter.sv
// Purpose : measures ring-oscillator frequency by counting synchronised osc_in
//           rising edges over a programmable window of gate_len_i clk cycles.
// Latency : start_i seen in cycle T -> ARM at T+1 -> COUNT at T+2..T+1+N ->
//           done_o and the new count_o at T+2+N (N = gate_len_i).
// Backpres: none. start_i, cont_i and gate_len_i are ignored while busy_o is high.
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous, active-high reset
//   osc_in_i     asynchronous ring-oscillator output
//   start_i      measurement request, sampled only in IDLE
//   cont_i       continuous mode, sampled together with start_i
//   gate_len_i   gate window length in clk cycles, sampled with start_i
//   busy_o       high in ARM, COUNT and DONE
//   done_o       one-cycle pulse when count_o/ovf_o are updated
//   count_o      edge count of the last completed measurement
//   ovf_o        last measurement saturated
//
// Accuracy: exact only while osc_in_i high and low phases each last at least
// one clk cycle. Faster inputs alias and this is not detected.
// SYNC_STAGES has a legal range of 2..4.
module rosc_freq_counter #(
    parameter int CNT_W       = 16,
    parameter int GATE_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              osc_in_i,
    input  logic              start_i,
    input  logic              cont_i,
    input  logic [GATE_W-1:0] gate_len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              ovf_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser and edge detector. These run in every state so that the
    // edge history is already valid when a window opens.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   osc_s;
    logic                   rise;

    assign osc_s = sync_q[SYNC_STAGES-1];
    assign rise  = osc_s & ~prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], osc_in_i};
            prev_q <= osc_s;
        end
    end

    // ------------------------------------------------------------------
    // Saturating edge counter next-state. Once the counter is at all-ones a
    // further edge cannot be represented, so the value holds and the
    // overflow flag records that edges were lost.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] edge_cnt_q;
    logic [CNT_W-1:0] edge_cnt_d;
    logic             ovf_flag_q;
    logic             ovf_flag_d;

    always_comb begin
        edge_cnt_d = edge_cnt_q;
        ovf_flag_d = ovf_flag_q;
        if (rise) begin
            if (&edge_cnt_q) begin
                ovf_flag_d = 1'b1;
            end else begin
                edge_cnt_d = edge_cnt_q + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs.
    // ------------------------------------------------------------------
    state_t           state_q;
    logic [GATE_W-1:0] gate_lat_q;
    logic [GATE_W-1:0] gate_cnt_q;
    logic             cont_q;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] count_q;
    logic             ovf_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            gate_lat_q <= '0;
            gate_cnt_q <= '0;
            cont_q     <= 1'b0;
            edge_cnt_q <= '0;
            ovf_flag_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // A zero-length window is rejected outright rather than
                    // producing a degenerate measurement.
                    if (start_i && (gate_len_i != '0)) begin
                        gate_lat_q <= gate_len_i;
                        cont_q     <= cont_i;
                        busy_q     <= 1'b1;
                        state_q    <= ST_ARM;
                    end
                end

                ST_ARM: begin
                    edge_cnt_q <= '0;
                    ovf_flag_q <= 1'b0;
                    gate_cnt_q <= gate_lat_q;
                    state_q    <= ST_COUNT;
                end

                ST_COUNT: begin
                    edge_cnt_q <= edge_cnt_d;
                    ovf_flag_q <= ovf_flag_d;
                    gate_cnt_q <= gate_cnt_q - GATE_W'(1);
                    // gate_cnt_q == 1 marks the last sampling cycle. The
                    // result is published from the next-state values so the
                    // edge seen in this final cycle is included and done_o
                    // is high during DONE itself.
                    if (gate_cnt_q == GATE_W'(1)) begin
                        count_q <= edge_cnt_d;
                        ovf_q   <= ovf_flag_d;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    // Continuous mode re-arms with the latched window and
                    // can only be left through reset.
                    if (cont_q) begin
                        state_q <= ST_ARM;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign count_o = count_q;
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_rosc_freq_counter.sv
// Bench for rosc_freq_counter: two instances (16-bit count with 2 sync stages,
// 4-bit count with 3 sync stages) share one stimulus stream. A window-based
// reference model predicts busy/done timing and the saturated edge counts.
module tb_rosc_freq_counter;

    localparam int S_BIG = 2;
    localparam int S_SML = 3;
    localparam int HMAX  = 20000;

    bit          clk = 1'b0;
    logic        rst = 1'b1;
    logic        osc = 1'b0;
    logic        start = 1'b0;
    logic        cont = 1'b0;
    logic [15:0] gate = '0;

    logic        busy_b, done_b, ovf_b;
    logic [15:0] count_b;
    logic        busy_s, done_s, ovf_s;
    logic [3:0]  count_s;

    always #5 clk = ~clk;

    rosc_freq_counter #(.CNT_W(16), .GATE_W(16), .SYNC_STAGES(S_BIG)) u_big (
        .clk_i(clk), .rst_i(rst), .osc_in_i(osc), .start_i(start), .cont_i(cont),
        .gate_len_i(gate), .busy_o(busy_b), .done_o(done_b), .count_o(count_b), .ovf_o(ovf_b)
    );

    rosc_freq_counter #(.CNT_W(4), .GATE_W(16), .SYNC_STAGES(S_SML)) u_sml (
        .clk_i(clk), .rst_i(rst), .osc_in_i(osc), .start_i(start), .cont_i(cont),
        .gate_len_i(gate), .busy_o(busy_s), .done_o(done_s), .count_o(count_s), .ovf_o(ovf_s)
    );

    // Stimulus knobs, applied once per cycle by tick().
    logic        drv_rst = 1'b1;
    logic        drv_start = 1'b0;
    logic        drv_cont = 1'b0;
    logic [15:0] drv_gate = '0;
    int          osc_mode = 0;    // 0: low, 1: periodic, 2: random per cycle, 3: high
    int          osc_per = 4;
    int          osc_hi = 2;

    // Reference model state.
    bit          osc_hist [0:HMAX-1];
    int          cyc = 99;
    int          last_rst = -100;
    bit          act = 1'b0;
    int          t0 = 0;
    int          n = 0;
    bit          ct = 1'b0;
    int          exp_cnt_b = 0, exp_cnt_s = 0;
    bit          exp_ovf_b = 1'b0, exp_ovf_s = 1'b0;
    bit          chk_en = 1'b0;

    int          checks = 0;
    int          errors = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Synchronised sample j as seen by an instance with s stages: reset clears
    // the chain and the edge history, which hides samples rst-s..rst.
    function automatic bit hv(input int j, input int s);
        if (j >= last_rst - s && j <= last_rst) return 1'b0;
        return osc_hist[j];
    endfunction

    // Rising edges of osc_in sampled in cycles whose synchronised image falls
    // inside the N counting cycles that follow a start accepted in cycle t.
    function automatic int count_rises(input int t, input int len, input int s);
        int r = 0;
        for (int j = t + 2 - s; j <= t + 1 + len - s; j++) begin
            if (hv(j, s) && !hv(j - 1, s)) r++;
        end
        return r;
    endfunction

    task automatic tick();
        bit v;
        bit exp_busy, exp_done;
        int r;
        @(negedge clk);
        cyc++;
        if (cyc >= HMAX) begin
            $display("FAIL cycle_budget: got %0d expected below %0d", cyc, HMAX);
            $fatal(1);
        end
        exp_busy = act && (cyc > t0) && (cyc <= t0 + n + 2);
        exp_done = act && (cyc == t0 + n + 2);
        if (exp_done) begin
            r = count_rises(t0, n, S_BIG);
            exp_cnt_b = (r > 65535) ? 65535 : r;
            exp_ovf_b = (r > 65535);
            r = count_rises(t0, n, S_SML);
            exp_cnt_s = (r > 15) ? 15 : r;
            exp_ovf_s = (r > 15);
        end
        if (chk_en) begin
            chk_eq("busy_big", busy_b, exp_busy);
            chk_eq("done_big", done_b, exp_done);
            chk_eq("count_big", count_b, exp_cnt_b);
            chk_eq("ovf_big", ovf_b, exp_ovf_b);
            chk_eq("busy_sml", busy_s, exp_busy);
            chk_eq("done_sml", done_s, exp_done);
            chk_eq("count_sml", count_s, exp_cnt_s);
            chk_eq("ovf_sml", ovf_s, exp_ovf_s);
        end

        case (osc_mode)
            1:       v = ((cyc % osc_per) < osc_hi);
            2:       v = 1'($urandom_range(0, 1));
            3:       v = 1'b1;
            default: v = 1'b0;
        endcase
        osc   = v;
        osc_hist[cyc] = v;
        start = drv_start;
        cont  = drv_cont;
        gate  = drv_gate;
        rst   = drv_rst;

        if (drv_rst) begin
            act = 1'b0;
            exp_cnt_b = 0; exp_ovf_b = 1'b0;
            exp_cnt_s = 0; exp_ovf_s = 1'b0;
            last_rst = cyc;
        end else if (drv_start && drv_gate != 16'd0 && !act) begin
            act = 1'b1; t0 = cyc; n = int'(drv_gate); ct = drv_cont;
        end else if (exp_done) begin
            if (ct) t0 = cyc;
            else    act = 1'b0;
        end
    endtask

    task automatic run(input int k);
        repeat (k) tick();
    endtask

    task automatic pulse_start(input int g, input bit c);
        drv_start = 1'b1; drv_gate = 16'(g); drv_cont = c;
        tick();
        drv_start = 1'b0;
    endtask

    task automatic pulse_rst();
        drv_rst = 1'b1;
        tick();
        drv_rst = 1'b0;
    endtask

    initial begin
        // Reset; checking starts once outputs are defined.
        drv_rst = 1'b1;
        run(4);
        chk_en = 1'b1;
        drv_rst = 1'b0;
        run(4);

        // Quiet oscillator, 50-cycle window.
        osc_mode = 0;
        pulse_start(50, 0);
        run(60);

        // Period-4 square wave, 100-cycle window: 25 edges, 4-bit saturates.
        osc_mode = 1; osc_per = 4; osc_hi = 2;
        pulse_start(100, 0);
        run(110);

        // Period-2 wave, 40-cycle window, then a quiet 10-cycle window.
        osc_per = 2; osc_hi = 1;
        pulse_start(40, 0);
        run(50);
        osc_mode = 0;
        pulse_start(10, 0);
        run(20);

        // Second start with a new gate while counting is ignored.
        osc_mode = 1; osc_per = 4; osc_hi = 2;
        pulse_start(100, 0);
        run(30);
        pulse_start(5, 0);
        run(80);
        // gate_len 0 in IDLE is ignored.
        pulse_start(0, 0);
        run(10);

        // Continuous mode, period 22, gate change mid-run, exit via reset.
        pulse_start(20, 1);
        run(30);
        drv_gate = 16'd7;
        run(60);
        pulse_rst();
        run(40);

        // Reset during the 10th counting cycle, then a clean rerun.
        drv_cont = 1'b0;
        pulse_start(100, 0);
        run(10);
        pulse_rst();
        run(5);
        pulse_start(100, 0);
        run(110);

        // Randomised phase.
        for (int it = 0; it < 40; it++) begin
            int len;
            osc_mode = $urandom_range(0, 3);
            osc_per  = $urandom_range(2, 9);
            osc_hi   = $urandom_range(1, osc_per - 1);
            pulse_start($urandom_range(0, 60), ($urandom_range(0, 3) == 0));
            len = $urandom_range(10, 140);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 19) == 0) begin
                    drv_start = 1'b1;
                    drv_gate  = 16'($urandom_range(0, 60));
                    drv_cont  = ($urandom_range(0, 3) == 0);
                end else begin
                    drv_start = 1'b0;
                end
                drv_rst = ($urandom_range(0, 199) == 0);
                tick();
            end
            drv_start = 1'b0;
            drv_rst   = 1'b0;
            if (act && ct) pulse_rst();
            run(70);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rosc_freq_counter.md
Name: rosc_freq_counter

Overview:
- Measurement stage directly downstream of the NAND ring oscillator.
- Takes the free-running, asynchronous oscillator output and synchronises it into the system clock domain.
- Counts its rising edges over a programmable gate window of clk cycles and publishes the edge count with a done pulse.
- Optional continuous mode re-arms automatically, so firmware/test logic can track oscillator frequency over time.

Parameters:
CNT_W, 16, width of edge counter and count output
GATE_W, 16, width of gate_len input (gate window in clk cycles)
SYNC_STAGES, 2, flip-flop stages in osc_in synchroniser (legal range 2..4)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
osc_in  input  1  asynchronous ring-oscillator output
start  input  1  request a measurement; sampled only in IDLE
cont  input  1  continuous mode; sampled together with start
gate_len  input  GATE_W  gate window length in clk cycles; sampled with start
busy  output  1  high in ARM, COUNT and DONE states
done  output  1  one-cycle pulse when count/ovf are updated
count  output  CNT_W  edge count of last completed measurement
ovf  output  1  last measurement saturated

Behaviour:
- Single clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - state=IDLE; busy=0, done=0, count=0, ovf=0.
  - Synchroniser chain and edge-history register = 0.
  - Internal gate/edge counters and latched cont = 0.
- Synchroniser:
  - osc_in passes through SYNC_STAGES flops to give osc_s.
  - prev register holds osc_s delayed by one cycle, updated every cycle in every state.
  - Rising edge = osc_s & ~prev.
- Accuracy: exact only when osc_in high and low phases each last at least one clk cycle (osc_in frequency at most clk/2). Faster inputs alias; this is not detected.
- FSM states: IDLE, ARM, COUNT, DONE.
  - IDLE: start=1 and gate_len!=0 -> latch gate_len and cont -> ARM. start=1 with gate_len==0 is ignored (stay IDLE, no done).
  - ARM (1 cycle): clear edge counter, load gate counter with latched gate_len -> COUNT. No edges counted.
  - COUNT: exactly gate_len cycles.
    - Each cycle, a detected rising edge increments the edge counter.
    - At all-ones the counter holds and an internal ovf flag sets.
    - The gate counter decrements; on the cycle it reaches 1 (last sampling cycle) -> DONE.
  - DONE (1 cycle): count<=edge counter, ovf<=flag, done=1. If latched cont=1 -> ARM; else -> IDLE.
- Latency: start sampled at cycle T -> ARM at T+1 -> COUNT at T+2..T+1+N -> done=1 and new count visible at T+2+N. N = gate_len.
- Continuous-mode period is N+2 cycles. Edges arriving during ARM/DONE are not counted.
- Continuous mode exits only via rst. start and cont are ignored while busy.
- Changing gate_len while busy has no effect on the current or re-armed measurement; the latched value is reused.
- count and ovf hold their values between done pulses. They change only in DONE or on rst.
- rst mid-measurement: next cycle is IDLE with all outputs at reset values; the partial count is discarded.
- Widths: no truncation. If GATE_W > CNT_W, saturation is the only overflow handling.

Test Plan:
- osc_in held 0, start with gate_len=50 -> done at T+52, count=0, ovf=0, busy high T+1..T+52.
- osc_in square wave, period 4 clk (2 high/2 low, synchronous to clk), gate_len=100, start -> count=25, ovf=0, single done pulse at T+102.
- Instance CNT_W=4; osc_in period 2 clk, gate_len=40 -> count=15, ovf=1. A following run with osc_in=0, gate_len=10 -> count=0, ovf=0.
- start pulsed again during COUNT with gate_len changed to 5 -> ignored: single done, original N timing, count unchanged by the second request; start with gate_len=0 in IDLE -> busy stays 0, no done.
- cont=1, period-4 osc, gate_len=20 -> done pulses every 22 cycles, each count=5; gate_len change mid-run has no effect; rst -> IDLE, count=0, no further done.
- rst asserted at 10th COUNT cycle of a period-4, gate_len=100 run -> next cycle busy=0, count=0, ovf=0; a new start then completes normally with count=25.
